// File: rtl/trans_feeder.sv
// Transaction feeder: assembles 16-byte frames (MSB first) into 128-bit words,
// buffers them in a small FIFO and presents each one until it is acknowledged.
module trans_feeder #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               in_data,
  input  logic                     in_first,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [127:0]             data_o,
  output logic                     valid_o,
  input  logic                     ack_i,
  output logic [15:0]              sent_count,
  output logic [7:0]               resync_count,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t         r_state;
  state_t         w_next;
  logic [3:0]     r_bcnt;
  logic [7:0]     r_bytes [15];
  logic [127:0]   r_mem [DEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [AW:0]    r_level;
  logic [127:0]   r_data;
  logic [15:0]    r_sent;
  logic [7:0]     r_resync;
  logic           w_accept;
  logic           w_push;
  logic           w_pop;
  logic           w_ackd;
  logic [127:0]   w_word;

  // Gated with rst_n so every output reads 0 while reset is held.
  assign in_ready = rst_n && (r_level != FULL);
  assign w_accept = in_valid && in_ready;
  assign w_push   = w_accept && !in_first && (r_bcnt == 4'd15);

  always_comb begin
    w_word = '0;
    for (int i = 0; i < 15; i++) begin
      w_word[127-8*i -: 8] = r_bytes[i];
    end
    w_word[7:0] = in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcnt   <= '0;
      r_resync <= '0;
      for (int i = 0; i < 15; i++) begin
        r_bytes[i] <= '0;
      end
    end else if (w_accept) begin
      if (in_first) begin
        r_bytes[0] <= in_data;
        r_bcnt     <= 4'd1;
        if (r_bcnt != 4'd0 && r_resync != 8'hFF) begin
          r_resync <= r_resync + 8'd1;
        end
      end else if (r_bcnt == 4'd15) begin
        r_bcnt <= 4'd0;
      end else if (r_bcnt != 4'd0) begin
        r_bytes[r_bcnt] <= in_data;
        r_bcnt          <= r_bcnt + 4'd1;
      end
    end
  end

  // Storage array carries no reset; only the pointers and level define contents.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    w_ackd = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_level != '0) begin
          w_pop  = 1'b1;
          w_next = PRESENT;
        end
      end
      PRESENT: begin
        if (ack_i) begin
          w_ackd = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Returning to IDLE after every ack enforces the one-cycle gap between words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_sent  <= '0;
    end else begin
      r_state <= w_next;
      if (w_pop) r_data <= r_mem[r_rptr];
      if (w_ackd && r_sent != 16'hFFFF) r_sent <= r_sent + 16'd1;
    end
  end

  assign data_o       = r_data;
  assign valid_o      = (r_state == PRESENT);
  assign sent_count   = r_sent;
  assign resync_count = r_resync;
  assign fifo_level   = r_level;

endmodule

// File: tb/tb_trans_feeder.sv
// Scoreboard bench for trans_feeder: a frame-level byte model predicts words,
// a monitor pops them as the DUT presents them.
module tb_trans_feeder;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   in_data = '0;
  logic         in_first = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] data_o;
  logic         valid_o;
  logic         ack_i = 1'b0;
  logic [15:0]  sent_count;
  logic [7:0]   resync_count;
  logic [$clog2(DEPTH):0] fifo_level;

  int totalChecks = 0;
  int badChecks = 0;
  int ackMode = 0;
  int cyc = 0;
  int expResync = 0;
  int wordsMade = 0;
  bit senderDone = 0;
  logic [127:0] expQ [$];
  logic [7:0]   frame [$];
  logic         prevValid = 1'b0;
  logic [127:0] heldWord = '0;

  trans_feeder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_first(in_first), .in_valid(in_valid), .in_ready(in_ready),
    .data_o(data_o), .valid_o(valid_o), .ack_i(ack_i),
    .sent_count(sent_count), .resync_count(resync_count), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    totalChecks++;
    if (act !== req) begin
      badChecks++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Frame-level model: a frame opens on first=1, stray bytes are ignored,
  // reopening a partial frame counts a resync, 16 bytes form one word.
  function automatic void modelByte(input logic [7:0] b, input bit f);
    logic [127:0] w;
    if (f) begin
      if (frame.size() > 0 && expResync < 255) expResync++;
      frame.delete();
      frame.push_back(b);
    end else if (frame.size() > 0) begin
      frame.push_back(b);
      if (frame.size() == 16) begin
        w = '0;
        foreach (frame[i]) w = {w[119:0], frame[i]};
        expQ.push_back(w);
        wordsMade++;
        frame.delete();
      end
    end
  endfunction

  task automatic applyStimulus(input logic [7:0] b, input bit f);
    int waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    in_first = f;
    while (!in_ready && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      totalChecks++;
      badChecks++;
      $display("[TB] FAIL byte_accept_timeout: in_ready stayed %b, expected 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    modelByte(b, f);
    #1 in_valid = 1'b0;
  endtask

  task automatic sendFrame(input logic [127:0] word);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(word[127-8*i -: 8], i == 0);
    end
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((expQ.size() != 0 || valid_o) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_done", 128'(n < 3000), 128'd1);
  endtask

  function automatic logic [127:0] randWord();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Acknowledge policy: 0 never, 1 immediately, 2 random, 3 every third cycle.
  always @(negedge clk) begin
    cyc++;
    case (ackMode)
      1:       ack_i = valid_o;
      2:       ack_i = valid_o && ($urandom_range(0, 2) == 0);
      3:       ack_i = valid_o && (cyc % 3 == 0);
      default: ack_i = 1'b0;
    endcase
  end

  // Monitor: each rising valid_o pops the next predicted word; held cycles must match it.
  always @(negedge clk) begin
    if (!rst_n) begin
      prevValid = 1'b0;
    end else begin
      if (valid_o && !prevValid) begin
        if (expQ.size() == 0) begin
          totalChecks++;
          badChecks++;
          $display("[TB] FAIL unexpected_word: got %h, expected no word", data_o);
        end else begin
          heldWord = expQ.pop_front();
          checkOutput("word", data_o, heldWord);
        end
      end else if (valid_o) begin
        checkOutput("hold", data_o, heldWord);
      end
      prevValid = valid_o;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [127:0] word1;
    int r;
    int n;
    word1 = {48'h000000000001, 48'h000000000002, 22'd50, 1'b1, 9'h000};

    repeat (3) @(negedge clk);
    checkOutput("rst_data", data_o, '0);
    checkOutput("rst_valid", 128'(valid_o), 128'd0);
    checkOutput("rst_ready", 128'(in_ready), 128'd0);
    checkOutput("rst_sent", 128'(sent_count), 128'd0);
    checkOutput("rst_resync", 128'(resync_count), 128'd0);
    checkOutput("rst_level", 128'(fifo_level), 128'd0);
    rst_n = 1'b1;

    $display("[TB] single transaction");
    sendFrame(word1);
    @(negedge clk);
    checkOutput("lat_valid_low", 128'(valid_o), 128'd0);
    checkOutput("lat_level", 128'(fifo_level), 128'd1);
    @(negedge clk);
    checkOutput("lat_valid_high", 128'(valid_o), 128'd1);
    checkOutput("single_word", data_o, word1);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 ackMode = 1;
    @(posedge clk);
    #1 ackMode = 0;
    @(negedge clk);
    checkOutput("ack_valid_low", 128'(valid_o), 128'd0);
    checkOutput("sent_one", 128'(sent_count), 128'd1);

    $display("[TB] stray byte");
    applyStimulus(8'hAA, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("stray_resync", 128'(resync_count), 128'd0);
    checkOutput("stray_level", 128'(fifo_level), 128'd0);
    checkOutput("stray_valid", 128'(valid_o), 128'd0);

    $display("[TB] resync");
    ackMode = 1;
    for (int i = 0; i < 7; i++) applyStimulus(8'($urandom), i == 0);
    sendFrame(randWord());
    waitDrain();
    checkOutput("resync_count", 128'(resync_count), 128'(expResync));
    checkOutput("resync_is_one", 128'(expResync), 128'd1);
    checkOutput("resync_sent", 128'(sent_count), 128'(wordsMade));

    $display("[TB] backpressure");
    ackMode = 0;
    senderDone = 0;
    fork
      begin
        for (int w = 0; w < 6; w++) sendFrame(randWord());
        senderDone = 1;
      end
    join_none
    repeat (16 * 5 + 30) @(negedge clk);
    checkOutput("bp_level", 128'(fifo_level), 128'(DEPTH));
    checkOutput("bp_ready", 128'(in_ready), 128'd0);
    checkOutput("bp_valid", 128'(valid_o), 128'd1);
    ackMode = 3;
    n = 0;
    while (!senderDone && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bp_sender_done", 128'(senderDone), 128'd1);
    waitDrain();
    checkOutput("bp_sent", 128'(sent_count), 128'(wordsMade));

    $display("[TB] ack timing and wrap");
    ackMode = 0;
    for (int w = 0; w < 5; w++) sendFrame(randWord());
    repeat (2) @(negedge clk);
    checkOutput("gap_level", 128'(fifo_level), 128'(DEPTH));
    @(posedge clk);
    #1 ackMode = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checkOutput("gap_pattern", 128'(valid_o), 128'(k % 2 == 0));
    end
    for (int w = 0; w < 5; w++) sendFrame(randWord());
    waitDrain();
    checkOutput("wrap_sent", 128'(sent_count), 128'(wordsMade));
    checkOutput("wrap_level", 128'(fifo_level), 128'd0);

    $display("[TB] random traffic");
    ackMode = 2;
    for (int it = 0; it < 12; it++) begin
      r = $urandom_range(0, 3);
      if (r < 2) begin
        sendFrame(randWord());
      end else if (r == 2) begin
        n = $urandom_range(1, 15);
        for (int i = 0; i < n; i++) applyStimulus(8'($urandom), i == 0);
      end else begin
        applyStimulus(8'($urandom), 1'b0);
      end
    end
    sendFrame(randWord());
    waitDrain();
    checkOutput("rand_sent", 128'(sent_count), 128'(wordsMade));
    checkOutput("rand_resync", 128'(resync_count), 128'(expResync));
    checkOutput("rand_level", 128'(fifo_level), 128'd0);

    $display("[TB] async reset");
    ackMode = 0;
    for (int w = 0; w < 4; w++) sendFrame(randWord());
    repeat (3) @(negedge clk);
    checkOutput("pre_rst_level", 128'(fifo_level), 128'd3);
    checkOutput("pre_rst_valid", 128'(valid_o), 128'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", 128'(valid_o), 128'd0);
    checkOutput("arst_data", data_o, '0);
    checkOutput("arst_level", 128'(fifo_level), 128'd0);
    checkOutput("arst_sent", 128'(sent_count), 128'd0);
    checkOutput("arst_resync", 128'(resync_count), 128'd0);
    checkOutput("arst_ready", 128'(in_ready), 128'd0);
    expQ.delete();
    frame.delete();
    expResync = 0;
    wordsMade = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("post_rst_idle", 128'(valid_o), 128'd0);
    ackMode = 1;
    sendFrame(randWord());
    waitDrain();
    checkOutput("post_rst_sent", 128'(sent_count), 128'(wordsMade));
    checkOutput("post_rst_one", 128'(wordsMade), 128'd1);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
